// File: rtl/spu_issue_pkg.sv
// Shared types and constants for the SPU dual-issue scoreboard, decode and instruction fetch.
package spu_issue_pkg;

   localparam int NUM_REGS   = 128;
   localparam int ADDR_W     = 7;
   localparam int LAT_W      = 3;
   localparam int STAT_W_DEF = 32;
   localparam int NUM_RD     = 8;

   localparam logic PIPE_EVEN = 1'b0;
   localparam logic PIPE_ODD  = 1'b1;

   localparam logic [LAT_W-1:0] LAT_FX1    = 3'd2;
   localparam logic [LAT_W-1:0] LAT_FX2    = 3'd3;
   localparam logic [LAT_W-1:0] LAT_BYTE   = 3'd4;
   localparam logic [LAT_W-1:0] LAT_SHUF   = 3'd4;
   localparam logic [LAT_W-1:0] LAT_LS     = 3'd6;
   localparam logic [LAT_W-1:0] LAT_SP_INT = 3'd7;

   typedef struct packed {
      logic              vld;
      logic              pipe;
      logic              use_a;
      logic              use_b;
      logic              use_c;
      logic [ADDR_W-1:0] src_a;
      logic [ADDR_W-1:0] src_b;
      logic [ADDR_W-1:0] src_c;
      logic              wr;
      logic [ADDR_W-1:0] dst;
      logic [LAT_W-1:0]  lat;
   } issue_req_t;

   // cnt == 1 means the value reaches the forward macro in time for a consumer.
   function automatic logic is_busy(input logic [LAT_W-1:0] cnt);
      return cnt > LAT_W'(1);
   endfunction

endpackage

// File: rtl/spu_sb_table.sv
// Per-register countdown/young table with two issue write ports, bulk decrement and flush squash.
module spu_sb_table
   import spu_issue_pkg::*;
(
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           stop,
   input  logic                           flush,
   input  logic                           we1,
   input  logic [ADDR_W-1:0]              wa1,
   input  logic [LAT_W-1:0]               wl1,
   input  logic                           we2,
   input  logic [ADDR_W-1:0]              wa2,
   input  logic [LAT_W-1:0]               wl2,
   input  logic [NUM_RD-1:0][ADDR_W-1:0]  raddr,
   output logic [NUM_RD-1:0][LAT_W-1:0]   rcnt
);

   logic [LAT_W-1:0]    cnt_q [NUM_REGS];
   logic [LAT_W-1:0]    cnt_d [NUM_REGS];
   logic [NUM_REGS-1:0] young_q;
   logic [NUM_REGS-1:0] young_d;

   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         cnt_d[r]   = cnt_q[r];
         young_d[r] = young_q[r];
         if (flush) begin
            young_d[r] = 1'b0;
            if (young_q[r]) begin
               cnt_d[r] = '0;
            end else if (!stop && cnt_q[r] != '0) begin
               cnt_d[r] = cnt_q[r] - LAT_W'(1);
            end
         end else if (!stop) begin
            young_d[r] = 1'b0;
            if (cnt_q[r] != '0) begin
               cnt_d[r] = cnt_q[r] - LAT_W'(1);
            end
         end
      end
      // The issue cycle is the first of the lat cycles, so the stored remainder is lat-1.
      if (we1) begin
         cnt_d[wa1]   = wl1 - LAT_W'(1);
         young_d[wa1] = 1'b1;
      end
      if (we2) begin
         cnt_d[wa2]   = wl2 - LAT_W'(1);
         young_d[wa2] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= '0;
         end
         young_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         young_q <= young_d;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_RD; i++) begin
         rcnt[i] = cnt_q[raddr[i]];
      end
   end

endmodule

// File: rtl/spu_issue_scoreboard.sv
// Dual-issue hazard check (RAW, WAW, pipe collision) between decode and register fetch.
module spu_issue_scoreboard
   import spu_issue_pkg::*;
#(
   parameter int STAT_W = STAT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stop,
   input  logic              flush,
   input  logic              vld1,
   input  logic              vld2,
   input  logic              pipe1,
   input  logic              pipe2,
   input  logic              use_a1,
   input  logic              use_b1,
   input  logic              use_c1,
   input  logic              use_a2,
   input  logic              use_b2,
   input  logic              use_c2,
   input  logic [ADDR_W-1:0] src_a1,
   input  logic [ADDR_W-1:0] src_b1,
   input  logic [ADDR_W-1:0] src_c1,
   input  logic [ADDR_W-1:0] src_a2,
   input  logic [ADDR_W-1:0] src_b2,
   input  logic [ADDR_W-1:0] src_c2,
   input  logic              wr1,
   input  logic              wr2,
   input  logic [ADDR_W-1:0] dst1,
   input  logic [ADDR_W-1:0] dst2,
   input  logic [LAT_W-1:0]  lat1,
   input  logic [LAT_W-1:0]  lat2,
   output logic              issue1,
   output logic              issue2,
   output logic              dep_stall_instr1,
   output logic              dep_stall_instr2,
   output logic [STAT_W-1:0] stall_cnt
);

   issue_req_t                      req1;
   issue_req_t                      req2;
   logic [NUM_RD-1:0][ADDR_W-1:0]   raddr;
   logic [NUM_RD-1:0][LAT_W-1:0]    rcnt;
   logic                            src1_busy;
   logic                            src2_busy;
   logic                            waw1;
   logic                            waw2;
   logic                            raw12;
   logic                            waw12;
   logic [STAT_W-1:0]               stall_cnt_q;
   logic [STAT_W-1:0]               stall_cnt_d;

   always_comb begin
      req1 = '{vld: vld1, pipe: pipe1, use_a: use_a1, use_b: use_b1, use_c: use_c1,
               src_a: src_a1, src_b: src_b1, src_c: src_c1, wr: wr1, dst: dst1, lat: lat1};
      req2 = '{vld: vld2, pipe: pipe2, use_a: use_a2, use_b: use_b2, use_c: use_c2,
               src_a: src_a2, src_b: src_b2, src_c: src_c2, wr: wr2, dst: dst2, lat: lat2};
      raddr = {req2.dst, req1.dst, req2.src_c, req2.src_b, req2.src_a,
               req1.src_c, req1.src_b, req1.src_a};
   end

   spu_sb_table u_table (
      .clk   (clk),
      .reset (reset),
      .stop  (stop),
      .flush (flush),
      .we1   (issue1 & req1.wr & (req1.lat != '0)),
      .wa1   (req1.dst),
      .wl1   (req1.lat),
      .we2   (issue2 & req2.wr & (req2.lat != '0)),
      .wa2   (req2.dst),
      .wl2   (req2.lat),
      .raddr (raddr),
      .rcnt  (rcnt)
   );

   always_comb begin
      src1_busy = (req1.use_a & is_busy(rcnt[0])) | (req1.use_b & is_busy(rcnt[1]))
                | (req1.use_c & is_busy(rcnt[2]));
      src2_busy = (req2.use_a & is_busy(rcnt[3])) | (req2.use_b & is_busy(rcnt[4]))
                | (req2.use_c & is_busy(rcnt[5]));
      waw1  = req1.wr & (rcnt[6] > req1.lat);
      waw2  = req2.wr & (rcnt[7] > req2.lat);
      raw12 = req1.wr & ((req2.use_a & (req2.src_a == req1.dst))
                       | (req2.use_b & (req2.src_b == req1.dst))
                       | (req2.use_c & (req2.src_c == req1.dst)));
      waw12 = req1.wr & req2.wr & (req1.dst == req2.dst);

      issue1 = !reset & req1.vld & !stop & !flush & !src1_busy & !waw1;
      issue2 = issue1 & req2.vld & (req2.pipe != req1.pipe) & !src2_busy & !waw2
             & !raw12 & !waw12;
      dep_stall_instr1 = !reset & req1.vld & !issue1 & !flush;
      dep_stall_instr2 = !reset & req2.vld & !issue2 & !flush;

      stall_cnt_d = stall_cnt_q;
      if (!stop && req1.vld && !issue1 && stall_cnt_q != '1) begin
         stall_cnt_d = stall_cnt_q + STAT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

   always_ff @(posedge clk) begin
      if (!reset && issue1 && req1.wr) begin
         assert (req1.lat != '0);
      end
      if (!reset && issue2 && req2.wr) begin
         assert (req2.lat != '0);
      end
   end

endmodule
